// File: rtl/sift_stage_sequencer.sv
// Stage scheduler for the SIFT core: one raster scan plus engine drain per stage
// (BLUR0..BLUR3, DETECT), publishing sticky per-stage completion flags.
module sift_stage_sequencer #(
  parameter int COLS  = 640,
  parameter int ROWS  = 480,
  parameter int COL_W = 10,
  parameter int ROW_W = 9,
  parameter int DRAIN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  output logic [2:0]       stage,
  output logic             scan_valid,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic [3:0]       gaussian_done,
  output logic             detect_filter_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(DRAIN + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BLUR0  = 3'd1,
    ST_BLUR1  = 3'd2,
    ST_BLUR2  = 3'd3,
    ST_BLUR3  = 3'd4,
    ST_DETECT = 3'd5,
    ST_DONE   = 3'd6
  } stage_e;

  typedef enum logic {
    PH_SCAN  = 1'b0,
    PH_DRAIN = 1'b1
  } phase_e;

  stage_e           stage_q, stage_d;
  phase_e           phase_q, phase_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gdone_q, gdone_d;
  logic             ddone_q, ddone_d;
  logic             scan_valid_q, scan_valid_d;
  logic             sof_q, eol_q, eof_q, busy_q;
  logic             sof_d, eol_d, eof_d, busy_d;
  logic [1:0]       blur_idx;

  assign blur_idx = 2'(3'(stage_q) - 3'd1);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    stage_d      = stage_q;
    phase_d      = phase_q;
    row_d        = row_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    gdone_d      = gdone_q;
    ddone_d      = ddone_q;
    scan_valid_d = scan_valid_q;

    case (stage_q)
      ST_IDLE: begin
        if (in_valid) begin
          gdone_d      = '0;
          ddone_d      = 1'b0;
          stage_d      = ST_BLUR0;
          phase_d      = PH_SCAN;
          row_d        = '0;
          col_d        = '0;
          scan_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!in_valid) stage_d = ST_IDLE;
      end
      default: begin
        // Stall freezes both the address walk and the drain count.
        if (!stall) begin
          if (phase_q == PH_SCAN) begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                row_d        = '0;
                phase_d      = PH_DRAIN;
                scan_valid_d = 1'b0;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            // This edge is the DRAIN-th drain edge: stage complete.
            cnt_d   = '0;
            phase_d = PH_SCAN;
            if (stage_q == ST_DETECT) begin
              ddone_d      = 1'b1;
              stage_d      = ST_DONE;
              scan_valid_d = 1'b0;
            end else begin
              gdone_d[blur_idx] = 1'b1;
              stage_d           = stage_e'(3'(stage_q) + 3'd1);
              scan_valid_d      = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase

    sof_d  = scan_valid_d && (row_d == '0) && (col_d == '0);
    eol_d  = scan_valid_d && (col_d == COL_LAST);
    eof_d  = scan_valid_d && (row_d == ROW_LAST) && (col_d == COL_LAST);
    busy_d = (stage_d != ST_IDLE) && (stage_d != ST_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q      <= ST_IDLE;
      phase_q      <= PH_SCAN;
      row_q        <= '0;
      col_q        <= '0;
      cnt_q        <= '0;
      gdone_q      <= '0;
      ddone_q      <= 1'b0;
      scan_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      phase_q      <= phase_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      gdone_q      <= gdone_d;
      ddone_q      <= ddone_d;
      scan_valid_q <= scan_valid_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
      busy_q       <= busy_d;
    end
  end

  assign stage              = 3'(stage_q);
  assign scan_valid         = scan_valid_q;
  assign row                = row_q;
  assign col                = col_q;
  assign sof                = sof_q;
  assign eol                = eol_q;
  assign eof                = eof_q;
  assign gaussian_done      = gdone_q;
  assign detect_filter_done = ddone_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_sift_stage_sequencer.sv
// Self-checking bench for sift_stage_sequencer on a 4x3 image with a 2-cycle drain:
// directed timing cases plus randomized stall runs checked by a beat scoreboard.
module tb_sift_stage_sequencer;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int DRAIN = 2;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, stall;
  logic [2:0] stage;
  logic       scan_valid, sof, eol, eof, detect_filter_done, busy;
  logic [8:0] row;
  logic [9:0] col;
  logic [3:0] gaussian_done;

  sift_stage_sequencer #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(10), .ROW_W(9), .DRAIN(DRAIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .stage(stage), .scan_valid(scan_valid), .row(row), .col(col),
    .sof(sof), .eol(eol), .eof(eof), .gaussian_done(gaussian_done),
    .detect_filter_done(detect_filter_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int stg;
    int r;
    int c;
    bit sof;
    bit eol;
    bit eof;
  } beat_t;

  beat_t sb[$];
  bit    mon_en = 1'b0;
  bit    in_gap = 1'b0;
  int    gap = 0;
  int    gap_stage = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flags {detect_filter_done, gaussian_done} after k completed stages.
  function automatic logic [31:0] exp_flags(input int k);
    if (k >= 5) return 32'h1f;
    if (k <= 0) return 32'h0;
    return 32'((1 << k) - 1);
  endfunction

  // Reference: every stage scans the full raster in order, one beat per pixel.
  task automatic push_run();
    beat_t b;
    for (int s = 1; s <= 5; s++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          b.stg = s; b.r = r; b.c = c;
          b.sof = (r == 0) && (c == 0);
          b.eol = (c == COLS - 1);
          b.eof = (r == ROWS - 1) && (c == COLS - 1);
          sb.push_back(b);
        end
  endtask

  // Monitor: consumes accepted beats and measures each drain gap.
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      in_gap = 1'b0;
      gap    = 0;
    end else begin
      if (in_gap) begin
        if (scan_valid || stage == 3'd6) begin
          check("drain_len", 32'(gap), 32'(DRAIN));
          check("flags_at_stage_end", 32'({detect_filter_done, gaussian_done}), exp_flags(gap_stage));
          check("stage_advance", 32'(stage), 32'(gap_stage + 1));
          if (stage == 3'd6) check("busy_in_done", 32'(busy), 32'd0);
          in_gap = 1'b0;
        end else begin
          check("flags_during_drain", 32'({detect_filter_done, gaussian_done}), exp_flags(gap_stage - 1));
          if (!stall) gap++;
        end
      end
      if (scan_valid && stall && sb.size() > 0) begin
        check("stall_row_hold", 32'(row), 32'(sb[0].r));
        check("stall_col_hold", 32'(col), 32'(sb[0].c));
      end
      if (scan_valid && !stall) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got stage %0d (%0d,%0d) expected none", stage, row, col);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_stage", 32'(stage), 32'(e.stg));
          check("beat_row", 32'(row), 32'(e.r));
          check("beat_col", 32'(col), 32'(e.c));
          check("beat_sof", 32'(sof), 32'(e.sof));
          check("beat_eol", 32'(eol), 32'(e.eol));
          check("beat_eof", 32'(eof), 32'(e.eof));
          check("beat_flags", 32'({detect_filter_done, gaussian_done}), exp_flags(e.stg - 1));
          check("beat_busy", 32'(busy), 32'd1);
          if (e.eof) begin
            in_gap    = 1'b1;
            gap       = 0;
            gap_stage = e.stg;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stage"}, 32'(stage), 32'd0);
    check({tag, "_scan_valid"}, 32'(scan_valid), 32'd0);
    check({tag, "_row"}, 32'(row), 32'd0);
    check({tag, "_col"}, 32'(col), 32'd0);
    check({tag, "_sof"}, 32'(sof), 32'd0);
    check({tag, "_eol"}, 32'(eol), 32'd0);
    check({tag, "_eof"}, 32'(eof), 32'd0);
    check({tag, "_gdone"}, 32'(gaussian_done), 32'd0);
    check({tag, "_ddone"}, 32'(detect_filter_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_flag(input int idx, input int c0, output int t);
    logic [4:0] fl;
    t = -1;
    for (int i = 0; i < 500; i++) begin
      fl = {detect_filter_done, gaussian_done};
      if (fl[idx]) begin
        t = cyc - c0;
        break;
      end
      tick();
    end
    if (t < 0) check($sformatf("timeout_flag%0d", idx), 32'd0, 32'd1);
  endtask

  task automatic wait_addr(input int s, input int r, input int c);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (scan_valid && stage == 3'(s) && row == 9'(r) && col == 10'(c)) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) check("timeout_addr", 32'd0, 32'd1);
  endtask

  task automatic finish_run();
    for (int i = 0; i < 3000; i++) begin
      if (stage == 3'd6) break;
      tick();
    end
    check("run_reaches_done", 32'(stage), 32'd6);
    stall    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("back_to_idle", 32'(stage), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic random_run();
    push_run();
    stall    = 1'b0;
    in_valid = 1'b1;
    tick();
    check("rand_start_stage", 32'(stage), 32'd1);
    check("rand_start_flags", 32'({detect_filter_done, gaussian_done}), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      if (stage == 3'd6) break;
      stall    = ($urandom_range(0, 3) == 0);
      in_valid = (stage == 3'd5) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    stall    = 1'b0;
    in_valid = 1'b1;
    tick();
    check("rand_hold_done", 32'(stage), 32'd6);
    finish_run();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, t;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    tick();
    check("idle_without_valid", 32'(stage), 32'd0);

    // Reset then start, then a full unstalled run.
    mon_en = 1'b1;
    push_run();
    in_valid = 1'b1;
    tick();
    c0 = cyc;
    check("start_stage", 32'(stage), 32'd1);
    check("start_scan_valid", 32'(scan_valid), 32'd1);
    check("start_sof", 32'(sof), 32'd1);
    for (int k = 0; k < 5; k++) begin
      wait_flag(k, c0, t);
      check($sformatf("flag%0d_cycle", k), 32'(t), 32'(14 * (k + 1)));
    end
    check("done_stage", 32'(stage), 32'd6);
    repeat (3) begin
      tick();
      check("done_hold_stage", 32'(stage), 32'd6);
      check("done_busy", 32'(busy), 32'd0);
      check("done_flags_hold", 32'({detect_filter_done, gaussian_done}), 32'h1f);
    end

    // Restart: flags held through IDLE, cleared on the start edge.
    in_valid = 1'b0;
    tick();
    check("restart_idle", 32'(stage), 32'd0);
    check("restart_idle_flags", 32'({detect_filter_done, gaussian_done}), 32'h1f);
    push_run();
    in_valid = 1'b1;
    tick();
    c0 = cyc;
    check("restart_stage", 32'(stage), 32'd1);
    check("restart_flags_clear", 32'({detect_filter_done, gaussian_done}), 32'd0);

    // Stall on (1,2) for five edges in BLUR0.
    wait_addr(1, 1, 2);
    stall = 1'b1;
    repeat (5) begin
      tick();
      check("stall_row", 32'(row), 32'd1);
      check("stall_col", 32'(col), 32'd2);
      check("stall_scan_valid", 32'(scan_valid), 32'd1);
    end
    stall = 1'b0;
    wait_flag(0, c0, t);
    check("stalled_blur0_cycle", 32'(t), 32'd19);

    // Stall three edges inside the BLUR2 drain.
    for (int i = 0; i < 500; i++) begin
      if (stage == 3'd3 && !scan_valid) break;
      tick();
    end
    check("blur2_drain_entered", 32'({stage, scan_valid}), 32'({3'd3, 1'b0}));
    stall = 1'b1;
    repeat (3) begin
      tick();
      check("drain_stall_scan_valid", 32'(scan_valid), 32'd0);
      check("drain_stall_gdone2", 32'(gaussian_done[2]), 32'd0);
    end
    stall = 1'b0;
    wait_flag(2, c0, t);
    check("blur2_delayed_cycle", 32'(t), 32'd50);
    wait_flag(4, c0, t);
    check("detect_delayed_cycle", 32'(t), 32'd78);
    finish_run();

    // Reset mid-run in BLUR3 at (1,1).
    push_run();
    in_valid = 1'b1;
    tick();
    wait_addr(4, 1, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    sb.delete();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    push_run();
    in_valid = 1'b1;
    tick();
    c0 = cyc;
    check("post_reset_flags", 32'({detect_filter_done, gaussian_done}), 32'd0);
    wait_flag(0, c0, t);
    check("post_reset_blur0_cycle", 32'(t), 32'd14);
    check("post_reset_flags_0001", 32'({detect_filter_done, gaussian_done}), 32'd1);
    finish_run();

    repeat (4) random_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
